// File: rtl/memory_map_generator_if.sv
// memory_map_generator_if: request/map handshake between the game FSM and the board generator.
interface memory_map_generator_if #(parameter int MAP_BITS = 64);
    logic                map_reset;
    logic [MAP_BITS-1:0] gen_map;
    logic                finished_gen;
    modport master (output map_reset, input gen_map, finished_gen);
    modport slave (input map_reset, output gen_map, finished_gen);
endinterface

// File: rtl/memory_map_generator.sv
// memory_map_generator: shuffles the ordered card pairs with an LFSR-driven Fisher-Yates pass.
module memory_map_generator #(
    parameter int BLOCKS_WIDE = 4,
    parameter int BLOCKS_HIGH = 4,
    parameter int BITS_PER_BLOCK = 4,
    parameter logic [BITS_PER_BLOCK-1:0] EMPTY_BLOCK = '0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic clk,
    input logic reset,
    memory_map_generator_if.slave bus
);
    localparam int N = BLOCKS_WIDE * BLOCKS_HIGH;
    localparam logic [1:0] CLEAR = 2'd0, SHUFFLE = 2'd1, DONE = 2'd2;
    logic [1:0] state;
    logic [3:0] idx, j, mask;
    logic [15:0] lfsr;
    logic finished;
    logic [BITS_PER_BLOCK-1:0] cells [N];
    // candidate masked to the smallest power of two covering 0..idx; rejected when above idx
    always_comb begin
        mask = idx >= 4'd8 ? 4'hF : idx >= 4'd4 ? 4'h7 : idx >= 4'd2 ? 4'h3 : 4'h1;
        j = lfsr[3:0] & mask;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= CLEAR;
            idx <= 4'(N - 1);
            lfsr <= LFSR_SEED;
            finished <= 1'b0;
            for (int k = 0; k < N; k++) cells[k] <= EMPTY_BLOCK;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (bus.map_reset || state == CLEAR) begin
                for (int k = 0; k < N; k++) cells[k] <= BITS_PER_BLOCK'(k / 2 + 1);
                idx <= 4'(N - 1);
                finished <= 1'b0;
                state <= bus.map_reset ? CLEAR : SHUFFLE;
            end else if (state == SHUFFLE && j <= idx) begin
                cells[idx] <= cells[j];
                cells[j] <= cells[idx];
                idx <= idx - 4'd1;
                if (idx == 4'd1) begin
                    state <= DONE;
                    finished <= 1'b1;
                end
            end
        end
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus.gen_map[g*BITS_PER_BLOCK +: BITS_PER_BLOCK] = cells[g];
    end
    assign bus.finished_gen = finished;
endmodule

// File: tb/tb_memory_map_generator.sv
// tb_memory_map_generator: predicts each board from a reference LFSR/shuffle model and scoreboards it.
module tb_memory_map_generator;
    localparam logic [15:0] SEED = 16'hACE1;
    typedef struct { logic [63:0] map; int lat; } exp_t;
    logic clk = 0, reset = 1;
    logic [15:0] m_lfsr;
    logic [63:0] first_board, ref_map;
    logic [63:0] boards [$];
    exp_t sb [$];
    int checks = 0, failures = 0;
    memory_map_generator_if #(.MAP_BITS(64)) bus ();
    memory_map_generator dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [15:0] adv(logic [15:0] l);
        return {^(l & 16'h002D), l[15:1]};
    endfunction
    always @(posedge clk or posedge reset)
        m_lfsr <= reset ? SEED : adv(m_lfsr);
    function automatic logic [63:0] ordered();
        logic [63:0] m;
        for (int k = 0; k < 16; k++) m[k*4 +: 4] = 4'(k / 2 + 1);
        return m;
    endfunction
    function automatic bit hist_ok(logic [63:0] m);
        int cnt [16];
        for (int c = 0; c < 16; c++) cnt[c] = 0;
        for (int k = 0; k < 16; k++) cnt[m[k*4 +: 4]]++;
        for (int c = 0; c < 16; c++)
            if (cnt[c] != ((c >= 1 && c <= 8) ? 2 : 0)) return 0;
        return 1;
    endfunction
    // board and edge count from a CLEAR load at the next edge, with lfsr l current now
    function automatic exp_t predict(logic [15:0] l);
        exp_t e;
        int c [16];
        int i, j, t;
        for (int k = 0; k < 16; k++) c[k] = k / 2 + 1;
        i = 15;
        e.lat = 1;
        while (i >= 1) begin
            l = adv(l);
            e.lat++;
            j = int'(l[3:0]) & ((1 << $clog2(i + 1)) - 1);
            if (j <= i) begin
                t = c[i]; c[i] = c[j]; c[j] = t;
                i--;
            end
        end
        for (int k = 0; k < 16; k++) e.map[k*4 +: 4] = 4'(c[k]);
        return e;
    endfunction
    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic wait_done();
        exp_t e;
        int n = 0;
        while (n < 1000 && !bus.finished_gen) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        check("finish_timeout", 64'(bus.finished_gen), 64'd1);
        if (bus.finished_gen) begin
            check("board", bus.gen_map, e.map);
            check("latency", 64'(n), 64'(e.lat));
            check("histogram", 64'(hist_ok(bus.gen_map)), 64'd1);
        end
    endtask
    task automatic release_map();
        bus.map_reset = 0;
        sb.push_back(predict(m_lfsr));
    endtask
    initial begin
        int distinct;
        bus.map_reset = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_map", bus.gen_map, 64'd0);
        check("reset_fin", 64'(bus.finished_gen), 64'd0);
        reset = 0;
        sb.push_back(predict(m_lfsr));
        wait_done();
        first_board = bus.gen_map;
        bus.map_reset = 1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            check("hold_fin", 64'(bus.finished_gen), 64'd0);
            check("hold_map", bus.gen_map, ordered());
        end
        release_map();
        wait_done();
        for (int r = 0; r < 50; r++) begin
            bus.map_reset = 1;
            repeat ($urandom_range(1, 1500)) @(posedge clk);
            #1;
            check("regen_fin_drop", 64'(bus.finished_gen), 64'd0);
            release_map();
            wait_done();
            boards.push_back(bus.gen_map);
        end
        distinct = 0;
        foreach (boards[a]) begin
            bit dup = 0;
            for (int b = 0; b < a; b++) if (boards[b] == boards[a]) dup = 1;
            if (!dup) distinct++;
        end
        check("distinct_ge45", 64'(distinct >= 45), 64'd1);
        bus.map_reset = 1;
        @(posedge clk);
        #1;
        release_map();
        repeat (5) @(posedge clk);
        #1;
        sb.delete();
        reset = 1;
        #1;
        check("midreset_map", bus.gen_map, 64'd0);
        check("midreset_fin", 64'(bus.finished_gen), 64'd0);
        @(posedge clk);
        #1;
        reset = 0;
        sb.push_back(predict(m_lfsr));
        wait_done();
        check("reseed_board", bus.gen_map, first_board);
        ref_map = bus.gen_map;
        distinct = 0;
        repeat (10000) begin
            @(posedge clk);
            #1;
            if (bus.gen_map !== ref_map || !bus.finished_gen) distinct++;
        end
        check("done_stable", 64'(distinct), 64'd0);
        bus.map_reset = 1;
        @(posedge clk);
        #1;
        release_map();
        repeat (4) @(posedge clk);
        #1;
        sb.delete();
        bus.map_reset = 1;
        @(posedge clk);
        #1;
        check("abort_map", bus.gen_map, ordered());
        check("abort_fin", 64'(bus.finished_gen), 64'd0);
        release_map();
        wait_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
